uart_port_responder: RTL
========================

Name: uart_port_responder

Overview:
- Device-side responder for the CPU serial-port strobe interface (rdn/wrn/data_ready/tbre/tsre, shared 8-bit data bus on the low byte of the RAM1 data lines).
- Replaces the external UART chip: accepts bytes strobed in by the memory controller and transmits them 8N1 on txd.
- Receives 8N1 frames on rxd and presents them to the controller for strobed reads.
- Sits between the memory controller's serial pins and the board's RS-232 lines.

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per serial bit (50 MHz / 115200). Must be ≥4.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, asynchronous, active-low
- rdn  input  1  read strobe from controller, active-low, asynchronous to CLK
- wrn  input  1  write strobe from controller, active-low, asynchronous to CLK
- data  inout  8  shared bus (ram1Data[7:0])
- data_ready  output  1  received byte waiting
- tbre  output  1  transmit buffer empty
- tsre  output  1  transmit shift register empty (line idle)
- rxd  input  1  serial receive line
- txd  output  1  serial transmit line

Behaviour:
- Reset (RST=0, asynchronous): txd=1, tbre=1, tsre=1, data_ready=0, data=Z, rx_hold=0, both FSMs idle, synchronizers=1.
- rdn, wrn, rxd: each passes through a 2-FF synchronizer (reset value 1). Edges are detected on the synchronized copies.
- Bus drive: data = rx_hold while raw rdn=0 and RST=1; otherwise Z. This path is combinational.
- Read completion: on a synchronized rdn rising edge, clear data_ready.
  - If an RX byte completes in the same cycle, the new byte wins: rx_hold is updated and data_ready stays 1.
- Write capture: while synchronized wrn=0, sample data into wr_cap every cycle.
  - On a synchronized wrn rising edge with tbre=1: tx_buf<=wr_cap, tbre<=0. This happens on the 3rd CLK edge after the pin rises.
  - With tbre=0, the write is dropped silently.
  - The initiator must hold data stable for ≥3 CLK before raising wrn.
- TX FSM (T_IDLE, T_START, T_DATA, T_STOP), baud counter 0..CLKS_PER_BIT-1, bit index 0..7:
  - T_IDLE: if tbre=0, shift<=tx_buf, tbre<=1, tsre<=0, txd<=0, go to T_START.
  - T_START: hold txd=0 for CLKS_PER_BIT cycles, then go to T_DATA.
  - T_DATA: send LSB first, each bit CLKS_PER_BIT cycles; after bit 7, go to T_STOP.
  - T_STOP: txd=1 for CLKS_PER_BIT cycles. At the end:
    - if tbre=0, reload from tx_buf (tbre<=1, txd<=0, go to T_START; tsre stays 0, back-to-back frames with no idle gap);
    - otherwise tsre<=1 and go to T_IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- RX FSM (R_IDLE, R_START, R_DATA, R_STOP) on synchronized rxd:
  - R_IDLE: on rxd=0, go to R_START.
  - R_START: after CLKS_PER_BIT/2 cycles, resample. If 1 (glitch), go to R_IDLE; if 0, go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles (mid-bit) into shift, LSB first; 8 samples.
  - R_STOP: sample after CLKS_PER_BIT cycles.
    - If 1: rx_hold<=shift, data_ready<=1. If data_ready was already 1, the old byte is overwritten.
    - If 0 (framing error): discard the byte and leave data_ready unchanged.
    - Return to R_IDLE.
- RX and TX run fully independently; simultaneous rdn and wrn activity is legal.
- Reset mid-frame: txd returns to 1 immediately; any partial TX/RX frame is discarded.

Test Plan (CLKS_PER_BIT=4):
- Reset check: hold RST=0 with rdn=0, wrn=0 -> txd=1, tbre=1, tsre=1, data_ready=0, data=Z.
- Write byte: drive data=8'hA5, pulse wrn low 4 CLK, release -> tbre=0 for 1 cycle, then tbre=1, tsre=0. txd sequence: 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles. tsre=1 exactly 40 cycles after the start bit begins.
- Back-to-back writes: write 8'h01, then 8'hFF while the first is shifting -> second frame starts immediately after the first stop bit, tsre stays 0 throughout, 80 cycles total. A third write while tbre=0 is dropped.
- Receive byte: drive rxd frame for 8'h3C -> data_ready=1 after the stop-bit sample. Pulse rdn low -> data=8'h3C while rdn=0. data_ready=0 three cycles after rdn rises.
- Error cases: a 1-cycle rxd low glitch -> no reception. Frame 8'h55 with stop bit 0 -> data_ready stays 0.
- Overrun and collision: receive 8'h11, then 8'h22 without reading -> data reads 8'h22. Complete a byte on the same cycle as the rdn rising edge is detected -> data_ready remains 1 with the new byte.

Source files
------------

// File: rtl/uart_port_responder.sv
// Device-side serial-port responder: strobed byte writes go out 8N1 on txd, and
// 8N1 frames on rxd are held for strobed reads on the shared low data byte.
module uart_port_responder #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rdn,
  input  logic       wrn,
  inout  wire  [7:0] data,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection
  logic [2:0] rdn_sync_q, wrn_sync_q;
  logic [1:0] rxd_sync_q;
  logic       rd_rise_c, wr_rise_c, rxd_s_c;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       tx_buf_q, tx_buf_d;
  logic [7:0]       wr_cap_q, wr_cap_d;
  logic             tbre_q, tbre_d;
  logic             tsre_q, tsre_d;
  logic             txd_q, txd_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_hold_q, rx_hold_d;
  logic             data_ready_q, data_ready_d;

  assign rd_rise_c = rdn_sync_q[1] & ~rdn_sync_q[2];
  assign wr_rise_c = wrn_sync_q[1] & ~wrn_sync_q[2];
  assign rxd_s_c   = rxd_sync_q[1];

  // Bus is driven straight from the raw strobe so read data appears without latency
  assign data = (!rdn && RST) ? rx_hold_q : 8'hzz;

  assign data_ready = data_ready_q;
  assign tbre       = tbre_q;
  assign tsre       = tsre_q;
  assign txd        = txd_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdn_sync_q   <= '1;
      wrn_sync_q   <= '1;
      rxd_sync_q   <= '1;
      tx_state_q   <= T_IDLE;
      tx_cnt_q     <= '0;
      tx_idx_q     <= '0;
      tx_shift_q   <= '0;
      tx_buf_q     <= '0;
      wr_cap_q     <= '0;
      tbre_q       <= 1'b1;
      tsre_q       <= 1'b1;
      txd_q        <= 1'b1;
      rx_state_q   <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_hold_q    <= '0;
      data_ready_q <= 1'b0;
    end else begin
      rdn_sync_q   <= {rdn_sync_q[1:0], rdn};
      wrn_sync_q   <= {wrn_sync_q[1:0], wrn};
      rxd_sync_q   <= {rxd_sync_q[0], rxd};
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_idx_q     <= tx_idx_d;
      tx_shift_q   <= tx_shift_d;
      tx_buf_q     <= tx_buf_d;
      wr_cap_q     <= wr_cap_d;
      tbre_q       <= tbre_d;
      tsre_q       <= tsre_d;
      txd_q        <= txd_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_hold_q    <= rx_hold_d;
      data_ready_q <= data_ready_d;
    end
  end

  // Write capture and transmit FSM; capture and FSM touch tbre under exclusive conditions
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    wr_cap_d   = wr_cap_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    txd_d      = txd_q;

    if (!wrn_sync_q[1]) wr_cap_d = data;
    if (wr_rise_c && tbre_q) begin
      tx_buf_d = wr_cap_q;
      tbre_d   = 1'b0;
    end

    case (tx_state_q)
      T_IDLE: begin
        if (!tbre_q) begin
          tx_shift_d = tx_buf_q;
          tbre_d     = 1'b1;
          tsre_d     = 1'b0;
          txd_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            txd_d    = tx_shift_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (!tbre_q) begin
            tx_shift_d = tx_buf_q;
            tbre_d     = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = T_START;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = T_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Receive FSM; a completing byte overrides a same-cycle read clear
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_hold_d    = rx_hold_q;
    data_ready_d = data_ready_q;

    if (rd_rise_c) data_ready_d = 1'b0;

    case (rx_state_q)
      R_IDLE: begin
        if (!rxd_s_c) begin
          rx_cnt_d   = '0;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rxd_s_c ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rxd_s_c;
          if (rx_idx_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (rxd_s_c) begin
            rx_hold_d    = rx_shift_q;
            data_ready_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

endmodule
